// File: rtl/ef_pwm_deadtime_if.sv
// ----------------------------------------------------------------------------
// ef_pwm_deadtime_if
// Bundle of the control, raw-PWM and gate-drive signals of the dead-time
// stage. The master side (PWM generator / controller) drives the control
// and raw PWM inputs. The slave side (the dead-time stage) drives the
// gate outputs and the fault status.
// ----------------------------------------------------------------------------
interface ef_pwm_deadtime_if #(
    parameter int DT_W = 8
);
    logic            en;
    logic            pwm_a;
    logic            pwm_b;
    logic [DT_W-1:0] dt_rise;
    logic [DT_W-1:0] dt_fall;
    logic            pol_hi;
    logic            pol_lo;
    logic            fault;
    logic            fault_clr;
    logic            a_hi;
    logic            a_lo;
    logic            b_hi;
    logic            b_lo;
    logic            fault_latched;

    modport master (
        output en, pwm_a, pwm_b, dt_rise, dt_fall, pol_hi, pol_lo,
               fault, fault_clr,
        input  a_hi, a_lo, b_hi, b_lo, fault_latched
    );

    modport slave (
        input  en, pwm_a, pwm_b, dt_rise, dt_fall, pol_hi, pol_lo,
               fault, fault_clr,
        output a_hi, a_lo, b_hi, b_lo, fault_latched
    );
endinterface

// File: rtl/ef_pwm_deadtime.sv
// ----------------------------------------------------------------------------
// ef_pwm_deadtime
// Two-channel dead-time insertion stage. Each raw PWM channel drives an
// OFF/LO/DR/HI/DF state machine with its own down-counter. The stage turns
// the channel into a complementary high-side/low-side pair. The hi and lo
// drives are never active at the same time, because both decode from one
// state register.
//
// The gate outputs are registered. Each output register is loaded from the
// decode of the next state, so an output changes on the same edge as its
// state and no input has a combinational path to an output.
//
// Optional feature macro: EF_PWM_DT_FAULT_EN
//   defined   - latched fault input forces both channels to OFF
//   undefined - fault/fault_clr ignored, fault_latched tied low
// ----------------------------------------------------------------------------
module ef_pwm_deadtime #(
    parameter int DT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    ef_pwm_deadtime_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_OFF = 3'd0,
        ST_LO  = 3'd1,
        ST_DR  = 3'd2,
        ST_HI  = 3'd3,
        ST_DF  = 3'd4
    } state_t;

    state_t          state_q [2];
    state_t          state_d [2];
    logic [DT_W-1:0] cnt_q   [2];
    logic [DT_W-1:0] cnt_d   [2];
    logic            hi_q    [2];
    logic            lo_q    [2];
    logic            pwm_s   [2];
    logic            fault_act_s;
    logic            force_off_s;

    assign pwm_s[0] = bus.pwm_a;
    assign pwm_s[1] = bus.pwm_b;

`ifdef EF_PWM_DT_FAULT_EN
    logic fault_q;

    // Fault latch: set wins over clear; clears only when fault is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (bus.fault) begin
            fault_q <= 1'b1;
        end else if (bus.fault_clr) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_q;
        end
    end

    assign fault_act_s       = bus.fault | fault_q;
    assign bus.fault_latched = fault_q;
`else
    logic unused_fault_s;

    assign unused_fault_s    = bus.fault ^ bus.fault_clr;
    assign fault_act_s       = 1'b0;
    assign bus.fault_latched = 1'b0;
`endif

    assign force_off_s = fault_act_s | ~bus.en;

    // Per-channel next-state and counter logic. Fault and disable force OFF.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            if (force_off_s) begin
                state_d[c] = ST_OFF;
                cnt_d[c]   = {DT_W{1'b0}};
            end else begin
                case (state_q[c])
                    ST_OFF: begin
                        // Both drives are already off, so no dead time is needed.
                        if (pwm_s[c]) begin
                            state_d[c] = ST_HI;
                        end else begin
                            state_d[c] = ST_LO;
                        end
                    end
                    ST_LO: begin
                        if (pwm_s[c]) begin
                            if (bus.dt_rise != {DT_W{1'b0}}) begin
                                state_d[c] = ST_DR;
                                cnt_d[c]   = bus.dt_rise - DT_W'(1);
                            end else begin
                                state_d[c] = ST_HI;
                            end
                        end else begin
                            state_d[c] = ST_LO;
                        end
                    end
                    ST_DR: begin
                        // A high pulse shorter than the dead time is swallowed.
                        if (!pwm_s[c]) begin
                            state_d[c] = ST_LO;
                        end else if (cnt_q[c] == {DT_W{1'b0}}) begin
                            state_d[c] = ST_HI;
                        end else begin
                            cnt_d[c] = cnt_q[c] - DT_W'(1);
                        end
                    end
                    ST_HI: begin
                        if (!pwm_s[c]) begin
                            if (bus.dt_fall != {DT_W{1'b0}}) begin
                                state_d[c] = ST_DF;
                                cnt_d[c]   = bus.dt_fall - DT_W'(1);
                            end else begin
                                state_d[c] = ST_LO;
                            end
                        end else begin
                            state_d[c] = ST_HI;
                        end
                    end
                    ST_DF: begin
                        // A low pulse shorter than the dead time is swallowed.
                        if (pwm_s[c]) begin
                            state_d[c] = ST_HI;
                        end else if (cnt_q[c] == {DT_W{1'b0}}) begin
                            state_d[c] = ST_LO;
                        end else begin
                            cnt_d[c] = cnt_q[c] - DT_W'(1);
                        end
                    end
                    default: begin
                        state_d[c] = ST_OFF;
                        cnt_d[c]   = {DT_W{1'b0}};
                    end
                endcase
            end
        end
    end

    // State, counter and registered gate-drive decode for both channels.
    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                state_q[c] <= ST_OFF;
                cnt_q[c]   <= {DT_W{1'b0}};
                hi_q[c]    <= bus.pol_hi;
                lo_q[c]    <= bus.pol_lo;
            end else begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
                hi_q[c]    <= (state_d[c] == ST_HI) ^ bus.pol_hi;
                lo_q[c]    <= (state_d[c] == ST_LO) ^ bus.pol_lo;
            end
        end
    end

    assign bus.a_hi = hi_q[0];
    assign bus.a_lo = lo_q[0];
    assign bus.b_hi = hi_q[1];
    assign bus.b_lo = lo_q[1];

endmodule

// File: tb/tb_ef_pwm_deadtime.sv
// ----------------------------------------------------------------------------
// tb_ef_pwm_deadtime
// Directed bench for the dead-time stage. pol_hi=0 and pol_lo=1 for the
// whole run: an active hi drive reads 1, and an active lo drive reads 0.
// Inputs change 1 ns after a rising edge and take effect at the next edge.
// ----------------------------------------------------------------------------
module tb_ef_pwm_deadtime;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    ef_pwm_deadtime_if #(.DT_W(8)) dut_if ();

    ef_pwm_deadtime #(.DT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one edge, then check that neither channel has hi and lo active together.
    task automatic step();
        @(posedge clk);
        #1;
        chk("no_overlap_a", (dut_if.a_hi === 1'b1) && (dut_if.a_lo === 1'b0), 1'b0);
        chk("no_overlap_b", (dut_if.b_hi === 1'b1) && (dut_if.b_lo === 1'b0), 1'b0);
    endtask

    task automatic chk_a(input string tag, input logic hi, input logic lo);
        chk({tag, "_a_hi"}, dut_if.a_hi, hi);
        chk({tag, "_a_lo"}, dut_if.a_lo, lo);
    endtask

    task automatic chk_b(input string tag, input logic hi, input logic lo);
        chk({tag, "_b_hi"}, dut_if.b_hi, hi);
        chk({tag, "_b_lo"}, dut_if.b_lo, lo);
    endtask

    initial begin
        logic p;
        total = 0;
        bad   = 0;
        rst              = 1'b1;
        dut_if.en        = 1'b0;
        dut_if.pwm_a     = 1'b0;
        dut_if.pwm_b     = 1'b0;
        dut_if.dt_rise   = 8'd0;
        dut_if.dt_fall   = 8'd0;
        dut_if.pol_hi    = 1'b0;
        dut_if.pol_lo    = 1'b1;
        dut_if.fault     = 1'b0;
        dut_if.fault_clr = 1'b0;

        // 1. reset: all drives inactive, no fault
        step(); step(); step();
        chk_a("reset", 1'b0, 1'b1);
        chk_b("reset", 1'b0, 1'b1);
        chk("reset_fault", dut_if.fault_latched, 1'b0);

        // 2. OFF -> LO, then rise with dt_rise=3 and fall with dt_fall=2
        rst            = 1'b0;
        dut_if.en      = 1'b1;
        dut_if.dt_rise = 8'd3;
        dut_if.dt_fall = 8'd2;
        step();
        chk_a("off_to_lo", 1'b0, 1'b0);
        chk_b("off_to_lo", 1'b0, 1'b0);
        step();
        dut_if.pwm_a = 1'b1;
        step(); chk_a("dr_k",  1'b0, 1'b1);
        step(); chk_a("dr_k1", 1'b0, 1'b1);
        step(); chk_a("dr_k2", 1'b0, 1'b1);
        step(); chk_a("hi_k3", 1'b1, 1'b1);
        step(); chk_a("hi_hold", 1'b1, 1'b1);
        dut_if.pwm_a = 1'b0;
        step(); chk_a("df_m",  1'b0, 1'b1);
        step(); chk_a("df_m1", 1'b0, 1'b1);
        step(); chk_a("lo_m2", 1'b0, 1'b0);

        // 3. short pulse on B swallowed by dt_rise=5
        dut_if.dt_rise = 8'd5;
        dut_if.pwm_b   = 1'b1;
        step(); chk_b("swallow_1", 1'b0, 1'b1);
        step(); chk_b("swallow_2", 1'b0, 1'b1);
        step(); chk_b("swallow_3", 1'b0, 1'b1);
        dut_if.pwm_b = 1'b0;
        step(); chk_b("swallow_back_lo", 1'b0, 1'b0);

        // 4. zero dead time: drives follow pwm_a one cycle later, no gap
        dut_if.dt_rise = 8'd0;
        dut_if.dt_fall = 8'd0;
        for (int i = 0; i < 6; i++) begin
            p = (i % 2 == 0) ? 1'b1 : 1'b0;
            dut_if.pwm_a = p;
            step();
            chk("dt0_a_hi", dut_if.a_hi, p);
            chk("dt0_a_lo", dut_if.a_lo, p);
        end
        dut_if.pwm_a = 1'b1;
        step(); chk_a("dt0_hi", 1'b1, 1'b1);

        // 5. fault handling
`ifdef EF_PWM_DT_FAULT_EN
        dut_if.fault = 1'b1;
        step();
        chk_a("fault_off", 1'b0, 1'b1);
        chk_b("fault_off", 1'b0, 1'b1);
        chk("fault_set", dut_if.fault_latched, 1'b1);
        dut_if.fault = 1'b0;
        step();
        chk("fault_held", dut_if.fault_latched, 1'b1);
        chk_a("fault_held", 1'b0, 1'b1);
        dut_if.fault     = 1'b1;
        dut_if.fault_clr = 1'b1;
        step();
        chk("fault_wins", dut_if.fault_latched, 1'b1);
        dut_if.fault = 1'b0;
        step();
        chk("fault_clr", dut_if.fault_latched, 1'b0);
        chk_a("fault_clr_still_off", 1'b0, 1'b1);
        dut_if.fault_clr = 1'b0;
        step();
        chk_a("resume", 1'b1, 1'b1);
        chk_b("resume", 1'b0, 1'b0);
`else
        dut_if.fault = 1'b1;
        step();
        chk_a("fault_ignored", 1'b1, 1'b1);
        chk("fault_tied", dut_if.fault_latched, 1'b0);
        dut_if.fault = 1'b0;
`endif

        // 6a. en dropped mid-DR; the counter is discarded on re-entry
        dut_if.dt_fall = 8'd0;
        dut_if.pwm_a   = 1'b0;
        step(); chk_a("pre_lo", 1'b0, 1'b0);
        dut_if.dt_rise = 8'd4;
        dut_if.pwm_a   = 1'b1;
        step(); chk_a("dr_enter", 1'b0, 1'b1);
        step();
        dut_if.en = 1'b0;
        step(); chk_a("en_off", 1'b0, 1'b1);
        chk_b("en_off", 1'b0, 1'b1);
        dut_if.en = 1'b1;
        step(); chk_a("en_reentry_hi", 1'b1, 1'b1);

        // 6b. rst asserted mid-DF
        dut_if.dt_fall = 8'd3;
        dut_if.pwm_a   = 1'b0;
        step(); chk_a("df_enter", 1'b0, 1'b1);
        step();
        rst = 1'b1;
        step(); chk_a("rst_mid_df", 1'b0, 1'b1);
        chk("rst_fault", dut_if.fault_latched, 1'b0);
        rst = 1'b0;
        step(); chk_a("rst_reentry_lo", 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
